// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage: output register plus one skid entry under a valid/ready
// handshake, with global stall, flush-to-bubble and a saturating bubble counter.
module exmem_skid_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned WB_W   = 2,
   parameter int unsigned M_W    = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              clr_cnt_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WB_W-1:0]   in_wb_i,
   input  logic [M_W-1:0]    in_m_i,
   input  logic [DATA_W-1:0] in_alu_i,
   input  logic [DATA_W-1:0] in_wdata_i,
   input  logic [REG_W-1:0]  in_rd_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [WB_W-1:0]   wb_o,
   output logic [M_W-1:0]    m_o,
   output logic [DATA_W-1:0] alu_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [REG_W-1:0]  rd_o,
   output logic [1:0]        occ_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   localparam int unsigned PAY_W = WB_W + M_W + DATA_W + DATA_W + REG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [PAY_W-1:0] out_pay_q, out_pay_d;
   logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PAY_W-1:0] in_pay;
   logic             in_fire, out_fire, out_adv;

   assign in_pay   = {in_wb_i, in_m_i, in_alu_i, in_wdata_i, in_rd_i};
   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_q & out_ready_i & ~stall_i;
   assign out_adv  = ~stall_i & (~out_valid_q | out_fire);

   // Entry movement: OUT refills from SKID first so ordering stays FIFO.
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_pay_d    = out_pay_q;
      skid_pay_d   = skid_pay_q;
      if (out_adv) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pay_d    = skid_pay_q;
            skid_valid_d = in_fire;
            if (in_fire) skid_pay_d = in_pay;
         end else begin
            out_valid_d = in_fire;
            if (in_fire) out_pay_d = in_pay;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_pay_d   = in_pay;
      end
      if (flush_i && !stall_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   // Bubble counter: clear wins, and is honoured even while stalled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt_i) begin
         cnt_d = '0;
      end else if (!stall_i && !out_valid_q && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_pay_q    <= '0;
         skid_pay_q   <= '0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_pay_q    <= out_pay_d;
         skid_pay_q   <= skid_pay_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready_o   = ~skid_valid_q & ~stall_i;
   assign out_valid_o  = out_valid_q;
   assign wb_o         = out_valid_q ? out_pay_q[PAY_W-1 -: WB_W] : '0;
   assign m_o          = out_valid_q ? out_pay_q[PAY_W-WB_W-1 -: M_W] : '0;
   assign alu_o        = out_pay_q[2*DATA_W+REG_W-1 -: DATA_W];
   assign wdata_o      = out_pay_q[DATA_W+REG_W-1 -: DATA_W];
   assign rd_o         = out_pay_q[REG_W-1:0];
   assign occ_o        = 2'(out_valid_q) + 2'(skid_valid_q);
   assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed scenarios plus random traffic, all checked
// against a queue-based model of a two-deep FIFO stage.
module tb_exmem_skid_stage;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, flush_i, clr_cnt_i, in_valid_i, out_ready_i;
   logic [1:0]  in_wb_i, in_m_i;
   logic [31:0] in_alu_i, in_wdata_i;
   logic [4:0]  in_rd_i;
   logic        in_ready_o, out_valid_o;
   logic [1:0]  wb_o, m_o, occ_o;
   logic [31:0] alu_o, wdata_o;
   logic [4:0]  rd_o;
   logic [15:0] bubble_cnt_o;
   // small-counter instance for saturation
   logic        s_in_ready, s_out_valid;
   logic [1:0]  s_wb, s_m, s_occ, s_cnt;
   logic [31:0] s_alu, s_wdata;
   logic [4:0]  s_rd;

   always #5 clk_i = ~clk_i;

   exmem_skid_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .clr_cnt_i(clr_cnt_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_wb_i(in_wb_i), .in_m_i(in_m_i), .in_alu_i(in_alu_i),
      .in_wdata_i(in_wdata_i), .in_rd_i(in_rd_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .wb_o(wb_o), .m_o(m_o), .alu_o(alu_o),
      .wdata_o(wdata_o), .rd_o(rd_o), .occ_o(occ_o), .bubble_cnt_o(bubble_cnt_o)
   );

   exmem_skid_stage #(.CNT_W(2)) dut_s (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .clr_cnt_i(clr_cnt_i), .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
      .in_wb_i(in_wb_i), .in_m_i(in_m_i), .in_alu_i(in_alu_i),
      .in_wdata_i(in_wdata_i), .in_rd_i(in_rd_i), .out_valid_o(s_out_valid),
      .out_ready_i(out_ready_i), .wb_o(s_wb), .m_o(s_m), .alu_o(s_alu),
      .wdata_o(s_wdata), .rd_o(s_rd), .occ_o(s_occ), .bubble_cnt_o(s_cnt)
   );

   typedef struct packed {
      logic [1:0]  wb;
      logic [1:0]  m;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } ent_t;

   ent_t        q[$];
   int unsigned m_cnt, m_cnt_s;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      check("in_ready", 64'(in_ready_o), 64'(n < 2 && !stall_i));
      check("out_valid", 64'(out_valid_o), 64'(n > 0));
      check("occ", 64'(occ_o), 64'(n));
      check("occ_s", 64'(s_occ), 64'(n));
      check("cnt", 64'(bubble_cnt_o), 64'(m_cnt));
      check("cnt_s", 64'(s_cnt), 64'(m_cnt_s));
      if (n > 0) begin
         check("wb", 64'(wb_o), 64'(q[0].wb));
         check("m", 64'(m_o), 64'(q[0].m));
         check("alu", 64'(alu_o), 64'(q[0].alu));
         check("wdata", 64'(wdata_o), 64'(q[0].wdata));
         check("rd", 64'(rd_o), 64'(q[0].rd));
      end else begin
         check("wb_bubble", 64'(wb_o), 64'(0));
         check("m_bubble", 64'(m_o), 64'(0));
      end
   endtask

   // One clock: check current outputs, then advance the model across the edge.
   task automatic step();
      bit   inf, outf;
      ent_t e;
      #1;
      check_all();
      inf  = in_valid_i && q.size() < 2 && !stall_i;
      outf = q.size() > 0 && out_ready_i && !stall_i;
      e.wb = in_wb_i; e.m = in_m_i; e.alu = in_alu_i; e.wdata = in_wdata_i; e.rd = in_rd_i;
      @(posedge clk_i);
      if (clr_cnt_i) begin
         m_cnt = 0; m_cnt_s = 0;
      end else if (!stall_i && q.size() == 0) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_s < 3) m_cnt_s++;
      end
      if (!stall_i) begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(e);
         if (flush_i) q.delete();
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu);
      in_valid_i = v;
      in_alu_i   = alu;
      in_wdata_i = ~alu;
      in_wb_i    = alu[1:0];
      in_m_i     = alu[3:2] | 2'b01;
      in_rd_i    = alu[8:4];
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt = 0; m_cnt_s = 0;
   endtask

   initial begin
      bit acc;
      int guard;
      rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
      out_ready_i = 1'b1;
      drive(1'b0, 32'h0);
      model_reset();
      #12;
      check("rst_out_valid", 64'(out_valid_o), 64'(0));
      check("rst_occ", 64'(occ_o), 64'(0));
      check("rst_in_ready", 64'(in_ready_o), 64'(1));
      check("rst_cnt", 64'(bubble_cnt_o), 64'(0));
      stall_i = 1'b1;
      #1 check("rst_in_ready_stall", 64'(in_ready_o), 64'(0));
      stall_i = 1'b0;
      @(negedge clk_i) rst_i = 1'b1;

      repeat (5) step();
      check("idle5_cnt", 64'(bubble_cnt_o), 64'(5));
      check("sat_cnt", 64'(s_cnt), 64'(3));
      clr_cnt_i = 1'b1; step(); clr_cnt_i = 1'b0;
      check("clr_cnt_s", 64'(s_cnt), 64'(0));

      // stream at full throughput
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 32'(k * 'h11));
         step();
         check("stream_alu", 64'(alu_o), 64'(k * 'h11));
      end
      drive(1'b0, 32'h0);
      repeat (2) step();

      // backpressure fills SKID, C stays upstream
      out_ready_i = 1'b0;
      drive(1'b1, 32'h11); step();
      drive(1'b1, 32'h22); step();
      drive(1'b1, 32'h33); step();
      check("bp_occ", 64'(occ_o), 64'(2));
      check("bp_in_ready", 64'(in_ready_o), 64'(0));
      check("bp_alu", 64'(alu_o), 64'(32'h11));

      // stall freezes a full stage
      stall_i = 1'b1; out_ready_i = 1'b1;
      repeat (3) step();
      check("stall_occ", 64'(occ_o), 64'(2));
      check("stall_alu", 64'(alu_o), 64'(32'h11));
      stall_i = 1'b0;
      guard = 0;
      do begin
         #1 acc = in_ready_o;
         step();
         guard++;
      end while (!acc && guard < 10);
      check("c_accepted", 64'(acc), 64'(1));
      drive(1'b0, 32'h0);
      repeat (4) step();

      // flush with D offered while full
      out_ready_i = 1'b0;
      drive(1'b1, 32'h44); step();
      drive(1'b1, 32'h55); step();
      flush_i = 1'b1; drive(1'b1, 32'hDD); step();
      flush_i = 1'b0; drive(1'b0, 32'h0);
      check("flush_occ", 64'(occ_o), 64'(0));
      check("flush_wb", 64'(wb_o), 64'(0));
      out_ready_i = 1'b1;
      repeat (3) step();

      // reset while holding an entry
      drive(1'b1, 32'h66); step(); drive(1'b0, 32'h0);
      rst_i = 1'b0;
      #1;
      model_reset();
      check("midrst_valid", 64'(out_valid_o), 64'(0));
      check("midrst_occ", 64'(occ_o), 64'(0));
      @(negedge clk_i) rst_i = 1'b1;

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom);
         out_ready_i = 1'($urandom_range(0, 3) != 0);
         stall_i     = 1'($urandom_range(0, 9) == 0);
         flush_i     = 1'($urandom_range(0, 19) == 0);
         clr_cnt_i   = 1'($urandom_range(0, 49) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
